dmem_bytelane: RTL and testbench
================================

Name: dmem_bytelane

Overview:
Parametrised data memory for the MIPS datapath, the successor to the fixed 16-word data memory. It adds byte-addressed access with byte, half and word sizes, and sign or zero extension on loads. Read latency is configurable and pipelined, with a valid strobe on return. It sits in the MEM stage, driven by the load/store unit, and returns load data to the writeback mux.

Parameters:
ADDR_W, 4, log2 of depth in 32-bit words (default 16 words); byte address bits used = ADDR_W+2
RD_LAT, 1, read latency in cycles from request accept to DMEM_rvalid; legal 1..4

Ports:
SYS_clk  input  1  system clock, all state on rising edge
SYS_reset  input  1  synchronous active-high reset
DMEM_req  input  1  request strobe; accepted every cycle it is high (no backpressure)
DMEM_we  input  1  1 = store, 0 = load; sampled with DMEM_req
DMEM_size  input  2  00 byte, 01 half, 10 word, 11 reserved
DMEM_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
DMEM_address  input  32  byte address
DMEM_data_in  input  32  store data, right-justified (byte in [7:0], half in [15:0])
DMEM_data_out  output  32  load data, valid when DMEM_rvalid=1, else 0
DMEM_rvalid  output  1  load-return strobe, one cycle per accepted load
DMEM_err  output  1  access error strobe (only with DMEM_ERR_EN)

Behaviour:
- Storage: 2**ADDR_W words x 32 bits, little-endian byte lanes. Word index = DMEM_address[ADDR_W+1:2]. Upper address bits are ignored (wrap).
- Reset (SYS_reset=1 at edge): clears the read pipeline and drives DMEM_rvalid=0, DMEM_data_out=0, DMEM_err=0. Memory contents are NOT cleared. Requests during reset are dropped, including writes. Reset mid-flight discards all pending loads: no rvalid for them.
- Store (req & we): committed at the accepting edge. Byte writes lane addr[1:0] from data_in[7:0]. Half writes lanes {addr[1],0} and {addr[1],1} from data_in[15:0]. Word writes all four lanes. Unwritten lanes are unchanged. Stores produce no rvalid.
- Load (req & !we): the memory word is read at the accepting edge (reflecting all earlier committed stores) and then travels through an RD_LAT-deep pipeline. Extraction and extension are done at issue: byte = lane addr[1:0], half = lanes at addr[1], extended per DMEM_unsigned; word is returned as-is.
- Timing: a load accepted at edge t gives DMEM_rvalid=1 with data after edge t+RD_LAT-1 (RD_LAT=1: the cycle after accept). Back-to-back loads return back-to-back in order.
- Store at edge t, load of the same word at edge t+1: the load sees the new data. A load accepted in the same cycle as nothing else is unaffected by a later store.
- Misalignment without DMEM_ERR_EN: half uses addr[1] only and ignores addr[0]; word ignores addr[1:0]; size 11 is treated as word.
- DMEM_data_out is 0 whenever DMEM_rvalid=0.

Optional Feature:
Macro DMEM_ERR_EN.
- Defined: a request is an error if it is misaligned (half with addr[0]=1, word with addr[1:0]!=0), uses size 11, or has any address bit above ADDR_W+1 nonzero. An erroneous store writes nothing. An erroneous load still returns rvalid with data 0 after RD_LAT. DMEM_err pulses for one cycle, aligned with when rvalid would occur (RD_LAT after accept) for both loads and stores.
- Undefined: DMEM_err is tied to 0 and the aliasing rules above apply.

Test Plan:
- Word store 0xDEADBEEF to addr 0x8, load word addr 0x8 next cycle (RD_LAT=1) -> rvalid one cycle later, data 0xDEADBEEF.
- Byte store 0x7F to addr 0x9 over 0xDEADBEEF -> word reads 0xDEAD7FEF. Signed byte load addr 0xB -> 0xFFFFFFDE. Unsigned -> 0x000000DE.
- Half store 0x8001 to addr 0xA -> word 0x80017FEF. Signed half load addr 0xA -> 0xFFFF8001. Unsigned -> 0x00008001.
- RD_LAT=3: loads on 4 consecutive cycles to addrs 0x0, 0x4, 0x8, 0xC -> 4 consecutive rvalid cycles starting 3 cycles after the first accept, data in order.
- Issue load (RD_LAT=3), assert SYS_reset one cycle later -> no rvalid ever for that load; outputs 0 during reset; memory word intact afterwards.
- With DMEM_ERR_EN: word store to addr 0x6 -> DMEM_err pulse, memory unchanged. Load half addr 0x41 with ADDR_W=4 -> err=1, rvalid=1, data 0.

Source files
------------

// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory with pipelined, sign/zero-extending loads.
// Optional DMEM_ERR_EN flags misaligned, reserved-size and out-of-range accesses.
module dmem_bytelane #(
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        DMEM_req,
    input  logic        DMEM_we,
    input  logic [1:0]  DMEM_size,
    input  logic        DMEM_unsigned,
    input  logic [31:0] DMEM_address,
    input  logic [31:0] DMEM_data_in,
    output logic [31:0] DMEM_data_out,
    output logic        DMEM_rvalid,
    output logic        DMEM_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] widx;
    logic [1:0]        lane;
    logic [31:0]       rword;
    logic              acc_err;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       ldata;
    logic [7:0]        bsel;
    logic [15:0]       hsel;
    logic              wr_en;
    logic              iss_v;
    logic              iss_e;

    logic              pv [RD_LAT];
    logic              pe [RD_LAT];
    logic [31:0]       pd [RD_LAT];

    assign widx  = DMEM_address[ADDR_W+1:2];
    assign lane  = DMEM_address[1:0];
    assign rword = mem[widx];

`ifdef DMEM_ERR_EN
    always_comb begin
        acc_err = 1'b0;
        case (DMEM_size)
            2'b01:   acc_err = DMEM_address[0];
            2'b10:   acc_err = |DMEM_address[1:0];
            2'b11:   acc_err = 1'b1;
            default: acc_err = 1'b0;
        endcase
        if (|DMEM_address[31:ADDR_W+2]) acc_err = 1'b1;
    end
`else
    logic unused_hi_addr;
    assign unused_hi_addr = ^DMEM_address[31:ADDR_W+2];
    assign acc_err        = 1'b0;
`endif

    // Stores replicate the narrow datum across lanes; be picks which land.
    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0;
        unique case (DMEM_size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{DMEM_data_in[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{DMEM_data_in[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = DMEM_data_in;
            end
        endcase
    end

    assign wr_en = DMEM_req & DMEM_we & ~SYS_reset & ~acc_err;

    always_ff @(posedge SYS_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign bsel = rword[8*lane +: 8];
    assign hsel = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ldata = 32'h0;
        unique case (DMEM_size)
            2'b00:   ldata = {{24{~DMEM_unsigned & bsel[7]}}, bsel};
            2'b01:   ldata = {{16{~DMEM_unsigned & hsel[15]}}, hsel};
            default: ldata = rword;
        endcase
        if (acc_err) ldata = 32'h0;
    end

    assign iss_v = DMEM_req & ~DMEM_we;
    assign iss_e = DMEM_req & acc_err;

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv[i] <= 1'b0;
                pe[i] <= 1'b0;
                pd[i] <= 32'h0;
            end
        end else begin
            pv[0] <= iss_v;
            pe[0] <= iss_e;
            pd[0] <= iss_v ? ldata : 32'h0;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign DMEM_rvalid   = pv[RD_LAT-1];
    assign DMEM_data_out = pv[RD_LAT-1] ? pd[RD_LAT-1] : 32'h0;
    assign DMEM_err      = pe[RD_LAT-1];

endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: RD_LAT=1 and RD_LAT=3 instances share stimulus
// and are checked every cycle against a byte-array reference model.
module tb_dmem_bytelane;

    logic        clk = 1'b0;
    logic        rst, req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, din;
    logic [31:0] d1_data, d3_data;
    logic        d1_v, d3_v, d1_e, d3_e;

    always #5 clk = ~clk;

    dmem_bytelane #(.ADDR_W(4), .RD_LAT(1)) u1 (
        .SYS_clk(clk), .SYS_reset(rst), .DMEM_req(req), .DMEM_we(we),
        .DMEM_size(size), .DMEM_unsigned(uns), .DMEM_address(addr),
        .DMEM_data_in(din), .DMEM_data_out(d1_data),
        .DMEM_rvalid(d1_v), .DMEM_err(d1_e));

    dmem_bytelane #(.ADDR_W(4), .RD_LAT(3)) u3 (
        .SYS_clk(clk), .SYS_reset(rst), .DMEM_req(req), .DMEM_we(we),
        .DMEM_size(size), .DMEM_unsigned(uns), .DMEM_address(addr),
        .DMEM_data_in(din), .DMEM_data_out(d3_data),
        .DMEM_rvalid(d3_v), .DMEM_err(d3_e));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] mb [0:63];
    bit         ev1 [0:4095];
    bit         ee1 [0:4095];
    bit [31:0]  ed1 [0:4095];
    bit         ev3 [0:4095];
    bit         ee3 [0:4095];
    bit [31:0]  ed3 [0:4095];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < 4096) begin
            check("u1_rvalid", d1_v, ev1[cyc]);
            check("u1_data", d1_data, ed1[cyc]);
            check("u1_err", d1_e, ee1[cyc]);
            check("u3_rvalid", d3_v, ev3[cyc]);
            check("u3_data", d3_data, ed3[cyc]);
            check("u3_err", d3_e, ee3[cyc]);
        end
    end

    task automatic drive(input logic r, input logic q, input logic w,
                         input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        int nb, base, start, nx;
        logic e;
        logic [31:0] v;
        rst = r; req = q; we = w; size = sz; uns = u; addr = a; din = d;
        nx = cyc + 1;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a[5:2]) * 4;
        start = int'(a[1:0]) & ~(nb - 1);
`ifdef DMEM_ERR_EN
        e = (sz == 2'd3) || ((int'(a[1:0]) % nb) != 0) || ((a >> 6) != 0);
`else
        e = 1'b0;
`endif
        if (r) begin
            for (int k = nx; k < 4096; k++) begin
                ev1[k] = 0; ee1[k] = 0; ed1[k] = 0;
                ev3[k] = 0; ee3[k] = 0; ed3[k] = 0;
            end
        end else if (q) begin
            if (w) begin
                if (!e)
                    for (int k = 0; k < nb; k++)
                        mb[base + start + k] = d[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < nb; k++)
                    v = v | (32'(mb[base + start + k]) << (8 * k));
                if (!u && nb < 4 && v[8*nb-1])
                    v = v | (32'hFFFF_FFFF << (8 * nb));
                if (e) v = 32'h0;
                ev1[cyc + 1] = 1; ed1[cyc + 1] = v;
                ev3[cyc + 3] = 1; ed3[cyc + 3] = v;
            end
            if (e) begin
                ee1[cyc + 1] = 1;
                ee3[cyc + 3] = 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ld(input logic [1:0] sz, input logic u,
                      input logic [31:0] a);
        drive(0, 1, 0, sz, u, a, 32'h0);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d);
        drive(0, 1, 1, sz, 0, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
            tick();
        end
    endtask

    initial begin
        drive(1, 0, 0, 2'd0, 0, 32'h0, 32'h0);
        tick();
        drive(1, 1, 1, 2'd2, 0, 32'h0, 32'h0);
        tick();
        check("reset_rvalid", d1_v, 1'b0);
        check("reset_data", d3_data, 32'h0);
        for (int i = 0; i < 16; i++) begin
            st(2'd2, 32'(i * 4), 32'h1000_0000 + 32'(i));
            tick();
        end

        st(2'd2, 32'h8, 32'hDEAD_BEEF); tick();
        ld(2'd2, 0, 32'h8); tick();
        check("lit_word_v", d1_v, 1'b1);
        check("lit_word", d1_data, 32'hDEAD_BEEF);

        st(2'd0, 32'h9, 32'h0000_007F); tick();
        ld(2'd2, 0, 32'h8); tick();
        check("lit_byte_st", d1_data, 32'hDEAD_7FEF);
        ld(2'd0, 0, 32'hB); tick();
        check("lit_lb", d1_data, 32'hFFFF_FFDE);
        ld(2'd0, 1, 32'hB); tick();
        check("lit_lbu", d1_data, 32'h0000_00DE);

        st(2'd1, 32'hA, 32'h0000_8001); tick();
        ld(2'd2, 0, 32'h8); tick();
        check("lit_half_st", d1_data, 32'h8001_7FEF);
        ld(2'd1, 0, 32'hA); tick();
        check("lit_lh", d1_data, 32'hFFFF_8001);
        ld(2'd1, 1, 32'hA); tick();
        check("lit_lhu", d1_data, 32'h0000_8001);
        idle(3);

        ld(2'd2, 0, 32'h0); tick();
        ld(2'd2, 0, 32'h4); tick();
        check("lat3_early", d3_v, 1'b0);
        ld(2'd2, 0, 32'h8); tick();
        check("lat3_first_v", d3_v, 1'b1);
        check("lat3_w0", d3_data, 32'h1000_0000);
        ld(2'd2, 0, 32'hC); tick();
        check("lat3_w1", d3_data, 32'h1000_0001);
        idle(1);
        check("lat3_w2", d3_data, 32'h8001_7FEF);
        idle(1);
        check("lat3_w3", d3_data, 32'h1000_0003);
        idle(1);
        check("lat3_done", d3_v, 1'b0);
        idle(2);

        ld(2'd2, 0, 32'hC); tick();
        drive(1, 1, 1, 2'd2, 0, 32'hC, 32'h0000_0BAD); tick();
        check("rst_u1_v", d1_v, 1'b0);
        check("rst_u3_v", d3_v, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("rst_flush_v", d3_v, 1'b0);
        end
        ld(2'd2, 0, 32'hC); tick();
        idle(2);
        check("rst_mem_v", d3_v, 1'b1);
        check("rst_mem", d3_data, 32'h1000_0003);
        idle(3);

`ifdef DMEM_ERR_EN
        st(2'd2, 32'h6, 32'h1234_5678); tick();
        check("err_st_u1", d1_e, 1'b1);
        idle(2);
        check("err_st_u3", d3_e, 1'b1);
        ld(2'd1, 0, 32'h41); tick();
        check("err_ld_e", d1_e, 1'b1);
        check("err_ld_v", d1_v, 1'b1);
        check("err_ld_d", d1_data, 32'h0);
        ld(2'd2, 0, 32'h4); tick();
        check("err_unchanged", d1_data, 32'h1000_0001);
`else
        ld(2'd1, 0, 32'hB); tick();
        check("alias_half", d1_data, 32'hFFFF_8001);
        ld(2'd3, 0, 32'h9); tick();
        check("alias_size3", d1_data, 32'h8001_7FEF);
        ld(2'd2, 0, 32'h48); tick();
        check("alias_wrap", d1_data, 32'h8001_7FEF);
        st(2'd2, 32'h6, 32'h1234_5678); tick();
        ld(2'd2, 0, 32'h4); tick();
        check("alias_word_st", d1_data, 32'h1234_5678);
`endif
        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
